// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display driver: active-low segment
// patterns (bit order g,f,e,d,c,b,a) and digit counts.
package seg_pkg;

    localparam int NUM_DIGITS = 6;
    // Digits that carry a code from the input word; the top digit is always blank.
    localparam int NUM_CODED  = 5;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg_decoder.sv
// Combinational digit-code to active-low segment pattern decoder.
// Codes 0-9 are numerals, A is a minus sign, B-F are blank.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        case (code)
            4'h0:    pattern = SEG_0;
            4'h1:    pattern = SEG_1;
            4'h2:    pattern = SEG_2;
            4'h3:    pattern = SEG_3;
            4'h4:    pattern = SEG_4;
            4'h5:    pattern = SEG_5;
            4'h6:    pattern = SEG_6;
            4'h7:    pattern = SEG_7;
            4'h8:    pattern = SEG_8;
            4'h9:    pattern = SEG_9;
            4'hA:    pattern = SEG_MINUS;
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_ctrl.sv
// Time-multiplexed 6-digit common-anode seven-segment scanner.
// Optional build macro LEAD_ZERO_BLANK_EN blanks leading zero digits.
module seg_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DP_POS   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [19:0]           dout,
    output logic [NUM_DIGITS-1:0] dis_sel,
    output logic [7:0]            dis_seg
);

    localparam int              CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [2:0]      IDX_MAX = 3'(NUM_DIGITS - 1);
    // Lowest digit eligible for leading-zero suppression: never the dp digit or below.
    localparam int              BLANK_LO = (DP_POS < NUM_DIGITS) ? DP_POS + 1 : 1;

    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [2:0]            idx_reg, idx_next;
    logic [NUM_DIGITS-1:0] sel_reg, sel_next;
    logic [7:0]            seg_reg, seg_next;

    logic [3:0]            code [0:NUM_CODED-1];
    logic [6:0]            pat  [0:NUM_CODED-1];
    logic [NUM_CODED-1:0]  supp;
    logic [6:0]            cur_pat;
    logic                  dp_lit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CODED; gi++) begin : g_dec
            assign code[gi] = dout[4*gi +: 4];
            seg_decoder u_dec (
                .code    (code[gi]),
                .pattern (pat[gi])
            );
        end
    endgenerate

`ifdef LEAD_ZERO_BLANK_EN
    // Walk down from the top digit while everything above is zero or blank.
    logic clear_above;
    always_comb begin
        supp        = '0;
        clear_above = 1'b1;
        for (int i = NUM_CODED - 1; i >= 1; i--) begin
            if (i >= BLANK_LO && code[i] == 4'h0 && clear_above)
                supp[i] = 1'b1;
            clear_above = clear_above && (code[i] == 4'h0 || code[i] >= 4'hB);
        end
    end
`else
    assign supp = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_reg <= '0;
            idx_reg <= '0;
            sel_reg <= '1;
            seg_reg <= 8'hFF;
        end else begin
            cnt_reg <= cnt_next;
            idx_reg <= idx_next;
            sel_reg <= sel_next;
            seg_reg <= seg_next;
        end
    end

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        idx_next = idx_reg;
        if (cnt_reg == CNT_MAX) begin
            cnt_next = '0;
            idx_next = (idx_reg == IDX_MAX) ? 3'd0 : idx_reg + 3'd1;
        end
    end

    // Outputs follow the current index and live dout, registered one cycle later.
    always_comb begin
        sel_next = ~(NUM_DIGITS'(1) << idx_reg);
        cur_pat  = SEG_BLANK;
        for (int i = 0; i < NUM_CODED; i++) begin
            if (idx_reg == 3'(i))
                cur_pat = supp[i] ? SEG_BLANK : pat[i];
        end
        dp_lit   = (DP_POS < NUM_DIGITS) && (int'(idx_reg) == DP_POS) && (cur_pat != SEG_BLANK);
        seg_next = {~dp_lit, cur_pat};
    end

    assign dis_sel = sel_reg;
    assign dis_seg = seg_reg;

endmodule

// File: tb/tb_seg_ctrl.sv
// Directed self-checking bench for seg_ctrl with SCAN_DIV=4, DP_POS=1.
module tb_seg_ctrl;

    localparam int DIV = 4;

    typedef struct {
        string      tag;
        logic [5:0] sel;
        logic [7:0] seg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] dout;
    logic [5:0]  dis_sel;
    logic [7:0]  dis_seg;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    seg_ctrl #(.SCAN_DIV(DIV), .DP_POS(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .dout    (dout),
        .dis_sel (dis_sel),
        .dis_seg (dis_seg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input string tag, input logic [5:0] sel, input logic [7:0] seg, input int n);
        exp_t e;
        e.tag = tag; e.sel = sel; e.seg = seg;
        for (int k = 0; k < n; k++) sb.push_back(e);
    endtask

    // Advance one clock per queued entry and compare outputs 1 time unit after the edge.
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            tests++;
            assert (dis_sel === e.sel) else begin
                fails++;
                $error("FAIL %s dis_sel got %h expected %h", e.tag, dis_sel, e.sel);
            end
            tests++;
            assert (dis_seg === e.seg) else begin
                fails++;
                $error("FAIL %s dis_seg got %h expected %h", e.tag, dis_seg, e.seg);
            end
            $display("[TB] %s sel=%h seg=%h", e.tag, dis_sel, dis_seg);
        end
    endtask

    function automatic logic [5:0] sel_of(input int d);
        logic [5:0] one;
        one = 6'b000001;
        return ~(one << d);
    endfunction

    logic [7:0] scan_a [6];
    logic [7:0] scan_b [6];
    logic [7:0] scan_c [6];

    initial begin
`ifdef LEAD_ZERO_BLANK_EN
        scan_a = '{8'hC0, 8'h3F, 8'hFF, 8'hF9, 8'hFF, 8'hFF};
        scan_b = '{8'h99, 8'h79, 8'hB0, 8'hFF, 8'hFF, 8'hFF};
`else
        scan_a = '{8'hC0, 8'h3F, 8'hFF, 8'hF9, 8'hC0, 8'hFF};
        scan_b = '{8'h99, 8'h79, 8'hB0, 8'hC0, 8'hC0, 8'hFF};
`endif
        scan_c = '{8'h92, 8'h24, 8'hC0, 8'hC0, 8'hBF, 8'hFF};

        // Reset held for two cycles
        rst_n = 1'b1;
        dout  = 20'h01BA0;
        push("reset", 6'h3F, 8'hFF, 2);
        drain();

        // Full scan of 01BA0
        rst_n = 1'b0;
        for (int d = 0; d < 6; d++) push($sformatf("scan_a d%0d", d), sel_of(d), scan_a[d], DIV);
        drain();

        // Wrap back to digit 0, then live update while digit 0 is lit
        push("wrap d0", 6'h3E, 8'hC0, 1);
        drain();
        dout = 20'h00314;
        push("live d0", 6'h3E, 8'h99, DIV - 1);
        for (int d = 1; d < 6; d++) push($sformatf("scan_b d%0d", d), sel_of(d), scan_b[d], DIV);
        drain();

        // Minus sign in the top coded digit
        dout = 20'hA0025;
        for (int d = 0; d < 3; d++) push($sformatf("scan_c d%0d", d), sel_of(d), scan_c[d], DIV);
        push("scan_c d3", sel_of(3), scan_c[3], 2);
        drain();

        // Reset mid-way through digit 3
        rst_n = 1'b1;
        push("midrst", 6'h3F, 8'hFF, 2);
        drain();
        rst_n = 1'b0;
        push("resume d0", 6'h3E, 8'h92, DIV);
        push("resume d1", 6'h3D, 8'h24, 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
